// File: rtl/csr_pkg.sv
// Shared definitions for the qtcore CSR bank: register addresses and STATUS_CTRL bit positions.
package csr_pkg;

    localparam logic [2:0] CSR_SEGEXE_L = 3'd0;
    localparam logic [2:0] CSR_SEGEXE_H = 3'd1;
    localparam logic [2:0] CSR_IO_IN    = 3'd2;
    localparam logic [2:0] CSR_IO_OUT   = 3'd3;
    localparam logic [2:0] CSR_CNT_L    = 3'd4;
    localparam logic [2:0] CSR_CNT_H    = 3'd5;
    localparam logic [2:0] CSR_STATUS   = 3'd6;
    localparam logic [2:0] CSR_TEMP     = 3'd7;

    localparam int ST_CNT_EN  = 0;
    localparam int ST_INT_EN  = 1;
    localparam int ST_OVF     = 2;
    localparam int ST_CNT_CLR = 3;

    // One-hot select for an 8-entry CSR address.
    function automatic logic [7:0] addr_decode(input logic [2:0] a);
        return 8'd1 << a;
    endfunction

endpackage

// File: rtl/csr_scan_reg.sv
// Plain read/write CSR that also forms one WIDTH-bit segment of the bank scan chain.
module csr_scan_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             scan_enable,
    input  logic             scan_in,
    input  logic             load_en,
    input  logic [WIDTH-1:0] load_data,
    output logic [WIDTH-1:0] q,
    output logic             scan_out
);

    logic [WIDTH-1:0] q_r;

    // Shift has priority over the parallel load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r <= '0;
        end else if (scan_enable) begin
            q_r <= {q_r[WIDTH-2:0], scan_in};
        end else if (load_en) begin
            q_r <= load_data;
        end
    end

    assign q        = q_r;
    assign scan_out = q_r[WIDTH-1];

endmodule

// File: rtl/csr_bank_timer.sv
// qtcore CSR bank: eight WIDTH-bit registers, a 2*WIDTH-bit overflow counter with
// coherent high-half read, synchronised IO input, and a full-bank scan chain.
module csr_bank_timer
    import csr_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       addr,
    input  logic [WIDTH-1:0] data_in,
    input  logic             wr_enable,
    input  logic             rd_enable,
    input  logic [WIDTH-1:0] IO_IN,
    input  logic             scan_enable,
    input  logic             scan_in,
    output logic [WIDTH-1:0] data_out,
    output logic [WIDTH-1:0] SEGEXE_L_OUT,
    output logic [WIDTH-1:0] SEGEXE_H_OUT,
    output logic [WIDTH-1:0] IO_OUT,
    output logic             INT_OUT,
    output logic             scan_out
);

    localparam int             CW      = 2 * WIDTH;
    localparam logic [CW-1:0]  CNT_ONE = CW'(1);

    logic [7:0]       wr_sel_s;
    logic [WIDTH-1:0] csr0_s, csr1_s, csr3_s, csr7_s;
    logic             csr0_so_s, csr1_so_s, csr3_so_s;
    logic [WIDTH-1:0] io_r, cnt_l_r, cnt_h_r, status_r, shadow_r;
    logic [WIDTH-1:0] io_src_s, status_nxt_s;
    logic [CW-1:0]    cnt_s, cnt_nxt_s;
    logic             cnt_clr_s, cnt_inc_s, ovf_set_s;

    // Writes are suppressed entirely while the chain is shifting.
    assign wr_sel_s = (wr_enable && !scan_enable) ? addr_decode(addr) : 8'd0;
    assign cnt_s    = {cnt_h_r, cnt_l_r};

    csr_scan_reg #(.WIDTH(WIDTH)) u_segexe_l (
        .clk         (clk),
        .rst_n       (rst),
        .scan_enable (scan_enable),
        .scan_in     (scan_in),
        .load_en     (wr_sel_s[CSR_SEGEXE_L]),
        .load_data   (data_in),
        .q           (csr0_s),
        .scan_out    (csr0_so_s)
    );

    csr_scan_reg #(.WIDTH(WIDTH)) u_segexe_h (
        .clk         (clk),
        .rst_n       (rst),
        .scan_enable (scan_enable),
        .scan_in     (csr0_so_s),
        .load_en     (wr_sel_s[CSR_SEGEXE_H]),
        .load_data   (data_in),
        .q           (csr1_s),
        .scan_out    (csr1_so_s)
    );

    csr_scan_reg #(.WIDTH(WIDTH)) u_io_out (
        .clk         (clk),
        .rst_n       (rst),
        .scan_enable (scan_enable),
        .scan_in     (io_r[WIDTH-1]),
        .load_en     (wr_sel_s[CSR_IO_OUT]),
        .load_data   (data_in),
        .q           (csr3_s),
        .scan_out    (csr3_so_s)
    );

    csr_scan_reg #(.WIDTH(WIDTH)) u_temp (
        .clk         (clk),
        .rst_n       (rst),
        .scan_enable (scan_enable),
        .scan_in     (status_r[WIDTH-1]),
        .load_en     (wr_sel_s[CSR_TEMP]),
        .load_data   (data_in),
        .q           (csr7_s),
        .scan_out    (scan_out)
    );

    // CSR 2 is the last synchroniser stage; the front stages live here.
    generate
        if (SYNC_STAGES > 1) begin : g_front
            logic [WIDTH-1:0] front_r [SYNC_STAGES-1];

            // Front synchroniser stages run freely; they are not part of the chain.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int i = 0; i < SYNC_STAGES - 1; i++) front_r[i] <= '0;
                end else begin
                    front_r[0] <= IO_IN;
                    for (int i = 1; i < SYNC_STAGES - 1; i++) front_r[i] <= front_r[i-1];
                end
            end

            assign io_src_s = front_r[SYNC_STAGES-2];
        end else begin : g_direct
            assign io_src_s = IO_IN;
        end
    endgenerate

    // Counter next value: clear, then half-writes, then increment.
    always_comb begin
        cnt_clr_s = wr_sel_s[CSR_STATUS] & data_in[ST_CNT_CLR];
        cnt_inc_s = status_r[ST_CNT_EN] & ~scan_enable;
        ovf_set_s = 1'b0;
        if (cnt_clr_s) begin
            cnt_nxt_s = '0;
        end else if (wr_sel_s[CSR_CNT_L]) begin
            cnt_nxt_s = {cnt_h_r, data_in};
        end else if (wr_sel_s[CSR_CNT_H]) begin
            cnt_nxt_s = {data_in, cnt_l_r};
        end else if (cnt_inc_s) begin
            cnt_nxt_s = cnt_s + CNT_ONE;
            ovf_set_s = &cnt_s;
        end else begin
            cnt_nxt_s = cnt_s;
        end
    end

    // STATUS next value: OVF is W1C but a same-edge overflow keeps it set.
    always_comb begin
        status_nxt_s = status_r;
        if (wr_sel_s[CSR_STATUS]) begin
            status_nxt_s         = data_in;
            status_nxt_s[ST_OVF] = ovf_set_s | (status_r[ST_OVF] & ~data_in[ST_OVF]);
        end else begin
            status_nxt_s[ST_CNT_CLR] = 1'b0;
            status_nxt_s[ST_OVF]     = status_r[ST_OVF] | ovf_set_s;
        end
    end

    // In-top chain segment: CSR1 -> IO_IN -> (CSR3) -> CNT_L -> CNT_H -> STATUS -> (CSR7).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            io_r     <= '0;
            cnt_l_r  <= '0;
            cnt_h_r  <= '0;
            status_r <= '0;
        end else if (scan_enable) begin
            io_r     <= {io_r[WIDTH-2:0], csr1_so_s};
            cnt_l_r  <= {cnt_l_r[WIDTH-2:0], csr3_so_s};
            cnt_h_r  <= {cnt_h_r[WIDTH-2:0], cnt_l_r[WIDTH-1]};
            status_r <= {status_r[WIDTH-2:0], cnt_h_r[WIDTH-1]};
        end else begin
            io_r               <= io_src_s;
            {cnt_h_r, cnt_l_r} <= cnt_nxt_s;
            status_r           <= status_nxt_s;
        end
    end

    // Shadow of the high half, captured when the low half is read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow_r <= '0;
        end else if (wr_sel_s[CSR_CNT_H]) begin
            shadow_r <= data_in;
        end else if (rd_enable && (addr == CSR_CNT_L)) begin
            shadow_r <= cnt_h_r;
        end
    end

    // Read mux; CNT_CLR always reads back as zero.
    always_comb begin
        data_out = '0;
        case (addr)
            CSR_SEGEXE_L: data_out = csr0_s;
            CSR_SEGEXE_H: data_out = csr1_s;
            CSR_IO_IN:    data_out = io_r;
            CSR_IO_OUT:   data_out = csr3_s;
            CSR_CNT_L:    data_out = cnt_l_r;
            CSR_CNT_H:    data_out = shadow_r;
            CSR_STATUS: begin
                data_out             = status_r;
                data_out[ST_CNT_CLR] = 1'b0;
            end
            CSR_TEMP:     data_out = csr7_s;
            default:      data_out = '0;
        endcase
    end

    assign SEGEXE_L_OUT = csr0_s;
    assign SEGEXE_H_OUT = csr1_s;
    assign IO_OUT       = csr3_s;
    assign INT_OUT      = status_r[ST_OVF] & status_r[ST_INT_EN];

endmodule

// File: doc/csr_bank_timer.md
Name: csr_bank_timer

Overview:
- Next-generation control/status register bank for the qtcore CPU: 8 WIDTH-bit CSRs (segment/execute limits, IO in/out, counter, status/control, temp) behind a 3-bit address.
- Adds a hardware 2*WIDTH-bit counter with overflow interrupt, coherent high-byte read, write-1-to-clear status, and a synchronised IO_IN.
- Keeps the full-bank serial scan chain used to load and dump CPU state.

Parameters:
- WIDTH, 8, bit width of every CSR and of the data bus; counter is 2*WIDTH bits.
- SYNC_STAGES, 2, flop stages on IO_IN before it becomes readable (legal range 1 to 4).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- addr  in  3  CSR select.
- data_in  in  WIDTH  write data.
- wr_enable  in  1  write strobe, sampled at clk.
- rd_enable  in  1  read strobe; used only for the CNT_H shadow capture.
- IO_IN  in  WIDTH  asynchronous external inputs.
- scan_enable  in  1  shift mode for the whole chain.
- scan_in  in  1  chain serial input.
- data_out  out  WIDTH  combinational read mux of addr.
- SEGEXE_L_OUT  out  WIDTH  CSR 0 contents.
- SEGEXE_H_OUT  out  WIDTH  CSR 1 contents.
- IO_OUT  out  WIDTH  CSR 3 contents.
- INT_OUT  out  1  interrupt request, equal to OVF & INT_EN.
- scan_out  out  1  chain serial output.

Behaviour:
- Address map:
  - 0 SEGEXE_L rw; 1 SEGEXE_H rw.
  - 2 IO_IN: read-only; writes are ignored.
  - 3 IO_OUT rw.
  - 4 CNT_L and 5 CNT_H: counter halves, rw.
  - 6 STATUS_CTRL; 7 TEMP rw.
- STATUS_CTRL bits:
  - [0] CNT_EN, rw.
  - [1] INT_EN, rw.
  - [2] OVF: set by hardware, write 1 to clear, writing 0 has no effect.
  - [3] CNT_CLR: write 1 to zero the counter on that edge; self-clears next cycle; always reads 0.
  - [WIDTH-1:4] scratch, rw.
- Reset (rst low, asynchronous): all CSRs, sync stages, counter and shadow are 0. Outputs: INT_OUT=0, scan_out=0, data_out=0.
- Writes: when wr_enable is high, the addressed CSR takes data_in at the clk edge; it is visible on data_out the next cycle.
- Counter:
  - Increments by 1 each clk while CNT_EN=1 and scan_enable=0.
  - All-ones wraps to 0 and sets OVF on that same edge.
  - Priority, highest first: scan shift, then CNT_CLR, then a CNT_L/CNT_H write, then increment.
  - A CNT_L write loads the low half, keeps the high half, and skips the increment that cycle. A CNT_H write does the same for the high half.
- OVF set and W1C on the same edge: set wins, OVF stays 1.
- Coherent read:
  - rd_enable with addr=4 copies the current high half into a shadow register at that edge.
  - data_out for addr=5 always returns the shadow, never the live high half.
  - A CNT_H write also updates the shadow with data_in.
- IO_IN path: passes through SYNC_STAGES flops. A stable input change is visible at addr 2 exactly SYNC_STAGES clk edges later. The last stage is the CSR 2 flop.
- INT_OUT is combinational from flops (OVF & INT_EN), with no extra latency.
- Scan:
  - While scan_enable=1, the 8 CSRs form one 8*WIDTH-bit chain and shift one bit per clk.
  - scan_in enters CSR0 bit 0; bits move toward the MSB; each CSRn MSB feeds CSRn+1 bit 0; CSR7 MSB drives scan_out.
  - During scan, writes, counting, the sync update and OVF setting are all blocked.
  - The IO_IN front sync stages and the shadow register are not in the chain.
  - CSR 6 bit 3 is in the chain, but the self-clear applies again once scan_enable falls.
- Reset mid-scan or mid-count: asynchronous clear to 0; no state survives.

Decomposition:
- Shared package csr_pkg holds:
  - address constants CSR_SEGEXE_L..CSR_TEMP (3'd0..3'd7);
  - STATUS bit indices ST_CNT_EN=0, ST_INT_EN=1, ST_OVF=2, ST_CNT_CLR=3.
- One sub-module, csr_scan_reg #(WIDTH): async active-low reset, parallel load with enable, and serial shift with scan priority. Instantiate it for CSRs 0, 1, 3 and 7.
- The counter, STATUS, IO_IN sync and shadow logic live in the top module.

Test Plan:
- Reset, then read addrs 0-7 -> every read returns 0; INT_OUT=0; scan_out=0.
- Write CNT_L=8'hFE, CNT_H=8'hFF, STATUS=8'h03 -> two cycles later the counter wraps to 0, OVF=1 and INT_OUT=1. Write STATUS=8'h07 -> OVF=0, INT_OUT=0, CNT_EN stays 1.
- Counter at 16'h12FF with CNT_EN=1: rd_enable at addr 4 returns 8'hFF. Next cycle, addr 5 returns the shadow 8'h12 even though the live high half is now 8'h13.
- IO_IN steps from 8'h00 to 8'hA5 with SYNC_STAGES=2 -> addr 2 reads 8'h00 after 1 edge and 8'hA5 after 2 edges. A write to addr 2 does not change the value read.
- Scan-in a 64-bit pattern with scan_enable=1 for 64 cycles -> each CSR holds its slice, SEGEXE_L_OUT/IO_OUT match, and the counter does not increment. A further 64 shifts reproduce the same pattern on scan_out.
- OVF setting (counter wraps) on the same edge as a STATUS write of 8'h04 -> OVF reads 1. Asserting rst low mid-count -> the counter reads 0 immediately, without waiting for a clk edge.
